wishbone_register_bank: RTL

Parametrised Wishbone classic slave that exposes NUM_REGS contiguous 32-bit word registers starting at BASE_ADDR in the Caravel user address space (0x3000_0000 and above).
- Supports byte-lane writes via wbs_sel_i.
- Supports per-register read-only status words.
- Generates a single-cycle ack per accepted access.
- Emits a one-cycle write-strobe pulse per register so user logic can react to host writes.
- Replaces single-register instances wherever several control/status words share one slave.

---
 rtl/wishbone_register_bank.sv | 97 +++++++++
 1 files changed

// File: rtl/wishbone_register_bank.sv
// Wishbone classic slave exposing NUM_REGS 32-bit words at BASE_ADDR.
// Read/write words support byte lanes; read-only words mirror status_i.
module wishbone_register_bank #(
    parameter logic [31:0]          BASE_ADDR   = 32'h3000_0000,
    parameter int                   NUM_REGS    = 4,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = {NUM_REGS{1'b0}},
    parameter logic [31:0]          RESET_VALUE = 32'h0000_0000
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_dat_i,
    input  logic [31:0]              wbs_adr_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [32*NUM_REGS-1:0]   reg_q_o,
    output logic [NUM_REGS-1:0]      reg_wr_o,
    input  logic [32*NUM_REGS-1:0]   status_i
);

    // One bit wider so BASE_ADDR near the top of the space cannot wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * NUM_REGS);

    logic                hit;
    logic                accept;
    logic [31:0]         offset;
    logic [31:0]         word_idx;

    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;
    logic [31:0]         regs_q [NUM_REGS];
    logic [31:0]         regs_d [NUM_REGS];

    assign hit = wbs_cyc_i & wbs_stb_i
               & (wbs_adr_i >= BASE_ADDR)
               & ({1'b0, wbs_adr_i} < END_ADDR);
    // Blocking accept while ack is high gives the one-transfer-per-two-cycles rhythm.
    assign accept   = hit & ~ack_q;
    assign offset   = wbs_adr_i - BASE_ADDR;
    assign word_idx = offset >> 2;

    always_comb begin
        ack_d    = accept;
        dat_d    = dat_q;
        reg_wr_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (accept && word_idx == 32'(i)) begin
                if (wbs_we_i) begin
                    if (!RO_MASK[i]) begin
                        reg_wr_d[i] = 1'b1;
                        for (int k = 0; k < 4; k++) begin
                            if (wbs_sel_i[k]) begin
                                regs_d[i][8*k +: 8] = wbs_dat_i[8*k +: 8];
                            end
                        end
                    end
                end else begin
                    dat_d = RO_MASK[i] ? status_i[32*i +: 32] : regs_q[i];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            reg_wr_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            reg_wr_q <= reg_wr_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign reg_wr_o  = reg_wr_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_q_o[32*g +: 32] = RO_MASK[g] ? 32'h0 : regs_q[g];
    end

endmodule
